uart_rx_deser: RTL
==================

UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per character.
REQ-002 SHALL have parameter CLK_FREQ, default 100_000_000, clk frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 115200, line rate in bit/s.
REQ-004 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port ready_i  input  1  consumer accepts data_o this cycle.
REQ-008 SHALL have port valid_o  output  1  data_o holds an unconsumed character.
REQ-009 SHALL have port data_o  output  DATA_WIDTH  received character, LSB first on line.
REQ-010 SHALL have port frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port overrun_o  output  1  one-cycle pulse: character dropped, output occupied.

Function
REQ-012 SHALL define CPB = CLK_FREQ / BAUD_RATE (truncating); elaboration SHALL fail if CPB < 4.
REQ-013 SHALL pass rx_i through a 2-flop synchronizer (both flops reset to 1); all decisions use the second flop (rx_s).
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH, plus a down-counter (width clog2(CPB)) and bit index.
REQ-015 IDLE: rx_s==0 -> START, counter loaded with CPB/2-1.
REQ-016 Each non-IDLE state decrements the counter; the "sample cycle" is the cycle the counter equals 0.
REQ-017 START sample: rx_s==0 -> DATA, counter=CPB-1, index=0; rx_s==1 -> IDLE (glitch rejected, no output, no flag).
REQ-018 DATA sample: shift rx_s into shift register at MSB (shift right), index+1, counter=CPB-1; after DATA_WIDTH samples -> STOP.
REQ-019 STOP sample with rx_s==1: character complete -> IDLE; with rx_s==0: frame_err_o pulses the next cycle, character discarded -> WAIT_HIGH.
REQ-020 WAIT_HIGH: remains until rx_s==1, then IDLE (a break condition yields exactly one frame_err_o pulse).
REQ-021 On character complete: if valid_o==0, or valid_o&ready_i in the same cycle, data_o<=shift register and valid_o<=1 on the next edge.
REQ-022 On character complete with valid_o==1 and ready_i==0: data_o unchanged, character dropped, overrun_o pulses the next cycle.
REQ-023 valid_o SHALL clear on the edge after valid_o&ready_i unless REQ-021 reloads it in that same cycle.
REQ-024 data_o SHALL remain stable while valid_o==1 and not consumed.
REQ-025 Latency: valid_o rises exactly 1 cycle after the STOP sample cycle; ready_i has no combinational path to any output.
REQ-026 The receiver SHALL accept a new start bit in the cycle after STOP completion (back-to-back characters, no idle gap).

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, counter 0, index 0, synchronizer flops 1, shift register 0, data_o 0, valid_o 0, frame_err_o 0, overrun_o 0.
REQ-028 Reset mid-character SHALL discard the partial character; after release, reception resumes only on a new falling edge of rx_s.

Structure
REQ-029 The state enum typedef and a cpb function (CLK_FREQ, BAUD_RATE) SHALL live in shared package uart_pkg, for reuse by the transmitter.
REQ-030 The synchronizer SHALL be a separate sub-module sync_2ff (reset value parameter); all other logic stays in uart_rx_deser.

Verification (CLK_FREQ=1_843_200, BAUD_RATE=115200 -> CPB=16, DATA_WIDTH=8)
REQ-031 Send 0xA5 (8N1), ready_i=1 -> valid_o high for 1 cycle with data_o=0xA5, 1 cycle after the STOP sample cycle (≈ 2+8+16*9 cycles after the falling edge).
REQ-032 Send 0x3C then 0xC3 back-to-back with ready_i=0 -> data_o=0x3C held, valid_o=1, overrun_o single pulse; then ready_i=1 -> valid_o clears and no 0xC3 appears.
REQ-033 Send 0x55 with stop bit driven low, then hold rx low 40 bit times -> exactly one frame_err_o pulse, valid_o stays 0; after rx high, 0x81 is received correctly.
REQ-034 6-cycle low glitch on idle line -> returns to IDLE, no valid_o/frame_err_o; a following 0x00 is received correctly.
REQ-035 Assert rst_n low during bit 4 of 0xFF, release with line high -> all outputs 0, no valid_o; next 0x12 is received correctly.
REQ-036 Characters 0x01 and 0x02 with ready_i asserted exactly in the cycle 0x02 completes -> data_o becomes 0x02, valid_o stays 1, no overrun_o.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and baud divisor helper.
package uart_pkg;

  // Smallest clocks-per-bit that still leaves room for a mid-bit sample point.
  localparam int unsigned MinCpb = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } uart_state_e;

  // Clocks per bit, truncating.
  function automatic int unsigned cpb(input int unsigned clk_freq, input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Both stages reset to ResetVal so an idle line never looks like an edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_deser.sv
// UART receiver: 8N1-style deserializer with mid-bit sampling, framing-error and
// overrun reporting, and a single-entry valid/ready output holding register.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int unsigned Cpb  = cpb(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CntW = (Cpb > 1) ? $clog2(Cpb) : 1;
  localparam int unsigned IdxW = $clog2(DATA_WIDTH + 1);

  // Half a bit minus one lands the start-bit check in the middle of the start bit.
  localparam logic [CntW-1:0] CntHalf = CntW'(Cpb / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Cpb - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);

  if (Cpb < MinCpb) begin : gen_cpb_check
    $error("uart_rx_deser: CLK_FREQ / BAUD_RATE must be at least 4");
  end

  // Synchronized line
  logic rx_s;

  sync_2ff #(
    .ResetVal(1'b1)
  ) u_sync_rx (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx_i),
    .q    (rx_s)
  );

  // Receive FSM state
  uart_state_e           state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;

  // Output holding register
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;

  logic cnt_zero;
  logic char_done;

  assign cnt_zero = (cnt_q == '0);

  // Receive FSM state, bit timer, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state: every non-idle state counts down to a sample cycle at cnt_q == 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    char_done   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = CntHalf;
        end
      end

      StStart: begin
        if (cnt_zero) begin
          if (!rx_s) begin
            state_d = StData;
            cnt_d   = CntFull;
            idx_d   = '0;
          end else begin
            // Line went high again before mid start bit: treat as a glitch.
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StData: begin
        if (cnt_zero) begin
          // LSB arrives first, so shift right and insert at the MSB.
          shift_d             = shift_q >> 1;
          shift_d[DATA_WIDTH-1] = rx_s;
          idx_d               = idx_q + 1'b1;
          cnt_d               = CntFull;
          if (idx_q == IdxLast) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StStop: begin
        if (cnt_zero) begin
          if (rx_s) begin
            char_done = 1'b1;
            state_d   = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StWaitHigh: begin
        // Hold off through a break so it reports a single framing error.
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output register: load on completion when empty or being drained, else flag overrun.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = 1'b0;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    if (char_done) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Registered outputs; ready_i only reaches outputs through these flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule
